// File: rtl/reg_op_sequencer_pkg.sv
// Shared constants for the register-operation sequencer: opcodes, FunSel codes,
// and the sequencer state encoding.
package reg_op_pkg;

   localparam logic [2:0] OP_LOAD_IMM = 3'd0;
   localparam logic [2:0] OP_CLEAR    = 3'd1;
   localparam logic [2:0] OP_INC      = 3'd2;
   localparam logic [2:0] OP_DEC      = 3'd3;
   localparam logic [2:0] OP_MEM16    = 3'd4;
   localparam logic [2:0] OP_MEM8_ZX  = 3'd5;
   localparam logic [2:0] OP_MEM8_SX  = 3'd6;
   localparam logic [2:0] OP_RSVD     = 3'd7;

   localparam logic [2:0] FS_DEC   = 3'b000;
   localparam logic [2:0] FS_INC   = 3'b001;
   localparam logic [2:0] FS_LOAD  = 3'b010;
   localparam logic [2:0] FS_CLR   = 3'b011;
   localparam logic [2:0] FS_LO_ZX = 3'b100;
   localparam logic [2:0] FS_LO    = 3'b101;
   localparam logic [2:0] FS_HI    = 3'b110;
   localparam logic [2:0] FS_LO_SX = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_RD_LO,
      S_WR_LO,
      S_RD_HI,
      S_WR_HI
   } state_t;

   // FunSel for the first (low-byte) write of a memory opcode.
   function automatic logic [2:0] mem_funsel(input logic [2:0] op);
      case (op)
         OP_MEM16:   mem_funsel = FS_LO;
         OP_MEM8_ZX: mem_funsel = FS_LO_ZX;
         default:    mem_funsel = FS_LO_SX;
      endcase
   endfunction

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Command, memory-read and register-control bundle of the sequencer.
interface reg_op_sequencer_if;

   logic        CmdValid;
   logic        CmdReady;
   logic [2:0]  CmdOp;
   logic [15:0] CmdData;
   logic [15:0] CmdAddr;
   logic [7:0]  CmdCount;
   logic        MemRd;
   logic [15:0] MemAddr;
   logic [7:0]  MemData;
   logic        RegE;
   logic [2:0]  RegFunSel;
   logic [15:0] RegI;
   logic        Done;
   logic        CmdErr;
   logic        Busy;

   modport slave (
      input  CmdValid, CmdOp, CmdData, CmdAddr, CmdCount, MemData,
      output CmdReady, MemRd, MemAddr, RegE, RegFunSel, RegI, Done, CmdErr, Busy
   );

   modport master (
      output CmdValid, CmdOp, CmdData, CmdAddr, CmdCount, MemData,
      input  CmdReady, MemRd, MemAddr, RegE, RegFunSel, RegI, Done, CmdErr, Busy
   );

endinterface

// File: rtl/reg_op_sequencer.sv
// Expands one accepted command into the one-cycle strobes of a 16-bit
// function-select register, fetching bytes over an 8-bit memory port.
module reg_op_sequencer
   import reg_op_pkg::*;
(
   input  logic         Clock,
   input  logic         Reset,
   reg_op_sequencer_if.slave bus
);

   state_t      state;
   logic [2:0]  op_r;
   logic [15:0] addr_r;
   logic [7:0]  cnt_r;

   logic        rege_r;
   logic [2:0]  funsel_r;
   logic [15:0] regi_r;
   logic        memrd_r;
   logic [15:0] memaddr_r;
   logic        done_r;
   logic        err_r;
   logic        busy_r;
   logic        wrmem_r;
   logic        cmd_ready;

   assign cmd_ready = (state == S_IDLE) && !Reset;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= S_IDLE;
         op_r      <= '0;
         addr_r    <= '0;
         cnt_r     <= '0;
         rege_r    <= 1'b0;
         funsel_r  <= '0;
         regi_r    <= '0;
         memrd_r   <= 1'b0;
         memaddr_r <= '0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         busy_r    <= 1'b0;
         wrmem_r   <= 1'b0;
      end else begin
         rege_r    <= 1'b0;
         funsel_r  <= '0;
         regi_r    <= '0;
         memrd_r   <= 1'b0;
         memaddr_r <= '0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         wrmem_r   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.CmdValid && cmd_ready) begin
                  op_r   <= bus.CmdOp;
                  addr_r <= bus.CmdAddr;
                  busy_r <= 1'b1;
                  cnt_r  <= '0;
                  state  <= S_EXEC;
                  case (bus.CmdOp)
                     OP_LOAD_IMM: begin
                        rege_r   <= 1'b1;
                        funsel_r <= FS_LOAD;
                        regi_r   <= bus.CmdData;
                        done_r   <= 1'b1;
                     end
                     OP_CLEAR: begin
                        rege_r   <= 1'b1;
                        funsel_r <= FS_CLR;
                        done_r   <= 1'b1;
                     end
                     OP_INC, OP_DEC: begin
                        // First strobe issues on acceptance; cnt_r holds the strobes still owed.
                        if (bus.CmdCount != 8'd0) begin
                           rege_r   <= 1'b1;
                           funsel_r <= (bus.CmdOp == OP_INC) ? FS_INC : FS_DEC;
                           cnt_r    <= bus.CmdCount - 8'd1;
                        end
                        done_r <= (bus.CmdCount <= 8'd1);
                     end
                     OP_RSVD: begin
                        done_r <= 1'b1;
                        err_r  <= 1'b1;
                     end
                     default: begin
                        memrd_r   <= 1'b1;
                        memaddr_r <= bus.CmdAddr;
                        state     <= S_RD_LO;
                     end
                  endcase
               end
            end

            S_EXEC: begin
               if (cnt_r == 8'd0) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end else begin
                  rege_r   <= 1'b1;
                  funsel_r <= (op_r == OP_INC) ? FS_INC : FS_DEC;
                  cnt_r    <= cnt_r - 8'd1;
                  done_r   <= (cnt_r == 8'd1);
               end
            end

            S_RD_LO: begin
               state    <= S_WR_LO;
               rege_r   <= 1'b1;
               wrmem_r  <= 1'b1;
               funsel_r <= mem_funsel(op_r);
               done_r   <= (op_r != OP_MEM16);
            end

            S_WR_LO: begin
               if (op_r == OP_MEM16) begin
                  state     <= S_RD_HI;
                  memrd_r   <= 1'b1;
                  memaddr_r <= addr_r + 16'd1;
               end else begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end
            end

            S_RD_HI: begin
               state    <= S_WR_HI;
               rege_r   <= 1'b1;
               wrmem_r  <= 1'b1;
               funsel_r <= FS_HI;
               done_r   <= 1'b1;
            end

            S_WR_HI: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end

            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Fetched bytes arrive during the write cycle itself, so RegI forwards MemData there.
   assign bus.RegI      = wrmem_r ? {bus.MemData, bus.MemData} : regi_r;
   assign bus.CmdReady  = cmd_ready;
   assign bus.RegE      = rege_r;
   assign bus.RegFunSel = funsel_r;
   assign bus.MemRd     = memrd_r;
   assign bus.MemAddr   = memaddr_r;
   assign bus.Done      = done_r;
   assign bus.CmdErr    = err_r;
   assign bus.Busy      = busy_r;

endmodule
